// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - writeback pipeline with per-register busy scoreboard and hazard stall
//
// Decodes destination/write-enable from op1/op3/op2, carries {valid,we,addr} down a
// PIPE_DEPTH-stage writeback pipe and tracks pending register writes in a busy vector.
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   issue_valid / issue_ready       decode handshake; accept = issue_valid & issue_ready
//   op1, op3, rd_rb, ra_op2         instruction fields used for dest/we decode
//   src_a/_used, src_b/_used        source registers checked for RAW hazards
//   flush                           kills all in-flight entries at the next edge
//   wb_valid, wb_we, wb_addr        retiring entry, drives the regfile write port
//   busy                            bit i set while a write to Ri is in flight
module wb_scoreboard #(
    parameter int RA_W       = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int BYPASS     = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [1:0]             op1,
    input  logic [3:0]             op3,
    input  logic [RA_W-1:0]        rd_rb,
    input  logic [RA_W-1:0]        ra_op2,
    input  logic [RA_W-1:0]        src_a,
    input  logic                   src_a_used,
    input  logic [RA_W-1:0]        src_b,
    input  logic                   src_b_used,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [RA_W-1:0]        wb_addr,
    output logic [(1<<RA_W)-1:0]   busy
);

    localparam int NREGS = 1 << RA_W;

    logic [2:0]         op2;
    logic [RA_W-1:0]    dest;
    logic               dec_we;
    logic [NREGS-1:0]   retire_mask;
    logic [NREGS-1:0]   busy_eff;
    logic [NREGS-1:0]   busy_next;
    logic               accept;

    logic [PIPE_DEPTH-1:0] st_valid;
    logic [PIPE_DEPTH-1:0] st_we;
    logic [RA_W-1:0]       st_addr [PIPE_DEPTH];

    assign op2 = ra_op2[2:0];

    always_comb begin
        dest   = (op1 == 2'b00) ? ra_op2 : rd_rb;
        dec_we = 1'b1;
        case (op1)
            2'b10:   dec_we = (op2 <= 3'd2);
            2'b11:   dec_we = !(op3 == 4'd7 || op3 == 4'd13 || op3 == 4'd14 || op3 == 4'd15);
            default: dec_we = 1'b1;
        endcase
    end

    // With bypass, the register being written back this cycle is already
    // available to the consumer, so it does not block issue.
    always_comb begin
        retire_mask = '0;
        if (BYPASS != 0 && wb_valid && wb_we)
            retire_mask[wb_addr] = 1'b1;
        busy_eff = busy & ~retire_mask;
    end

    assign issue_ready = ~flush
                       & ~(src_a_used & busy_eff[src_a])
                       & ~(src_b_used & busy_eff[src_b])
                       & ~(dec_we & busy_eff[dest]);
    assign accept = issue_valid & issue_ready;

    // Clear before set so a same-register retire/issue pair leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (wb_valid && wb_we)
            busy_next[wb_addr] = 1'b0;
        if (accept && dec_we)
            busy_next[dest] = 1'b1;
    end

    // Address fields only load behind a valid entry, so wb_addr keeps the
    // last retired destination through bubbles and flushes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
            st_we    <= '0;
            busy     <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++)
                st_addr[i] <= '0;
        end else if (flush) begin
            st_valid <= '0;
            st_we    <= '0;
            busy     <= '0;
        end else begin
            st_valid[0] <= accept;
            st_we[0]    <= accept & dec_we;
            if (accept)
                st_addr[0] <= dest;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_we[i]    <= st_we[i-1];
                if (st_valid[i-1])
                    st_addr[i] <= st_addr[i-1];
            end
            busy <= busy_next;
        end
    end

    assign wb_valid = st_valid[PIPE_DEPTH-1];
    assign wb_we    = st_we[PIPE_DEPTH-1];
    assign wb_addr  = st_addr[PIPE_DEPTH-1];

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - self-checking bench for wb_scoreboard with an in-flight-list model
module tb_wb_scoreboard;

    localparam int D   = 3;
    localparam int BYP = 1;

    logic       clock, reset;
    logic       issue_valid, issue_ready;
    logic [1:0] op1;
    logic [3:0] op3;
    logic [2:0] rd_rb, ra_op2, src_a, src_b;
    logic       src_a_used, src_b_used, flush;
    logic       wb_valid, wb_we;
    logic [2:0] wb_addr;
    logic [7:0] busy;

    wb_scoreboard #(.RA_W(3), .PIPE_DEPTH(D), .BYPASS(BYP)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op1(op1), .op3(op3), .rd_rb(rd_rb), .ra_op2(ra_op2),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .flush(flush),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: list of accepted instructions stamped with the edge count at
    // which they were accepted. Age 0..D-1 = pending, age D-1 = retiring.
    typedef struct {
        logic       we;
        logic [2:0] addr;
        int         t;
    } ent_t;

    ent_t       q[$];
    int         e = 0;
    logic [2:0] last_addr = 3'd0;
    logic       exp_ready = 1'b0;
    int         nvec = 0;
    int         nerr = 0;

    function automatic logic m_we(input logic [1:0] o1, input logic [3:0] o3, input logic [2:0] o2);
        if (o1 == 2'd2) return o2 inside {3'd0, 3'd1, 3'd2};
        if (o1 == 2'd3) return !(o3 inside {4'd7, 4'd13, 4'd14, 4'd15});
        return 1'b1;
    endfunction

    function automatic logic [2:0] m_dest(input logic [1:0] o1, input logic [2:0] rd, input logic [2:0] ra);
        return (o1 == 2'd0) ? ra : rd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [7:0] eb, blocked;
        logic       v, w;
        logic [2:0] a, d;
        logic       dw;
        eb = 8'h00; v = 1'b0; w = 1'b0; a = 3'd0;
        foreach (q[i]) begin
            if (q[i].we && (e - q[i].t) < D) eb[q[i].addr] = 1'b1;
            if ((e - q[i].t) == D - 1) begin
                v = 1'b1; w = q[i].we; a = q[i].addr;
            end
        end
        if (v) last_addr = a;
        blocked = eb;
        if (BYP != 0 && v && w) blocked[a] = 1'b0;
        d  = m_dest(op1, rd_rb, ra_op2);
        dw = m_we(op1, op3, ra_op2);
        exp_ready = !flush && !(src_a_used && blocked[src_a])
                  && !(src_b_used && blocked[src_b]) && !(dw && blocked[d]);
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("wb_valid",    32'(wb_valid),    32'(v));
        chk("wb_we",       32'(wb_we),       32'(v && w));
        chk("wb_addr",     32'(wb_addr),     32'(last_addr));
        chk("busy",        32'(busy),        32'(eb));
    endtask

    task automatic update();
        if (!reset) begin
            if (flush) q.delete();
            else if (issue_valid && exp_ready)
                q.push_back('{m_we(op1, op3, ra_op2), m_dest(op1, rd_rb, ra_op2), e + 1});
        end
        e++;
        while (q.size() > 0 && (e - q[0].t) >= D) void'(q.pop_front());
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step();
        if (reset) begin
            q.delete();
            last_addr = 3'd0;
        end
        #1 compare();
        @(posedge clock);
        update();
        @(negedge clock);
    endtask

    task automatic set_in(input logic v, input logic [1:0] o1, input logic [3:0] o3,
                          input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] sa, input logic sau,
                          input logic [2:0] sb, input logic sbu, input logic fl);
        issue_valid = v; op1 = o1; op3 = o3; rd_rb = rd; ra_op2 = ra;
        src_a = sa; src_a_used = sau; src_b = sb; src_b_used = sbu; flush = fl;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        idle(2);
        chk("reset_busy", 32'(busy), 32'h00);
        chk("reset_wb_valid", 32'(wb_valid), 32'h0);
        chk("reset_wb_addr", 32'(wb_addr), 32'h0);
        reset = 1'b0;
        idle(1);

        // Reset mid-flight: write R5 in flight, then reset.
        set_in(1'b1, 2'd0, 4'd0, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        chk("midflight_busy_set", 32'(busy), 32'h20);
        set_in(1'b0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 chk("midflight_busy_cleared", 32'(busy), 32'h00);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midflight_no_retire", 32'(wb_valid), 32'h0);
        end

        // Latency/decode: op1=11 op3=0 rd_rb=2.
        set_in(1'b1, 2'd3, 4'd0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        chk("lat_busy2_set", 32'(busy), 32'h04);
        idle(1);
        chk("lat_not_yet", 32'(wb_valid), 32'h0);
        idle(1);
        chk("lat_wb_valid", 32'(wb_valid), 32'h1);
        chk("lat_wb_we", 32'(wb_we), 32'h1);
        chk("lat_wb_addr", 32'(wb_addr), 32'h2);
        idle(1);
        chk("lat_busy2_clear", 32'(busy), 32'h00);
        idle(2);

        // No-write ops: op1=11 op3=7, then op1=10 op2=3.
        set_in(1'b1, 2'd3, 4'd7, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        chk("nowr_busy_a", 32'(busy), 32'h00);
        set_in(1'b1, 2'd2, 4'd0, 3'd6, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        chk("nowr_busy_b", 32'(busy), 32'h00);
        idle(1);
        chk("nowr_a_valid", 32'(wb_valid), 32'h1);
        chk("nowr_a_we", 32'(wb_we), 32'h0);
        idle(1);
        chk("nowr_b_valid", 32'(wb_valid), 32'h1);
        chk("nowr_b_we", 32'(wb_we), 32'h0);
        idle(3);

        // RAW: R3 in flight, consumer reads R3; ready only in retire cycle.
        set_in(1'b1, 2'd0, 4'd0, 3'd0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 2'd3, 4'd7, 3'd0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("raw_ready", 32'(issue_ready), (k == 2) ? 32'h1 : 32'h0);
            step();
        end
        idle(4);

        // WAW set-wins: new write to R4 accepted while R4 retires.
        set_in(1'b1, 2'd1, 4'd0, 3'd4, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        idle(2);
        chk("waw_retiring", 32'(wb_addr), 32'h4);
        set_in(1'b1, 2'd1, 4'd0, 3'd4, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1 chk("waw_ready", 32'(issue_ready), 32'h1);
        step();
        chk("waw_busy4_kept", 32'(busy), 32'h10);
        idle(4);

        // Flush with three entries in flight and an offered issue.
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, 2'd1, 4'd0, 3'(k), 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, 2'd1, 4'd0, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        #1 chk("flush_ready", 32'(issue_ready), 32'h0);
        chk("flush_retire_shows", 32'(wb_valid), 32'h1);
        chk("flush_retire_addr", 32'(wb_addr), 32'h1);
        step();
        chk("flush_busy", 32'(busy), 32'h00);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("flush_no_retire", 32'(wb_valid), 32'h0);
        end

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 29) == 0));
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
